switch_debouncer: RTL and testbench

//  Input-side counterpart to the board's LED drivers: samples raw DIP-switch/pushbutton pins.

---
 rtl/switch_debouncer.sv | 162 ++++++++++++++++
 tb/tb_switch_debouncer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose:
//   Input-side partner to the board's LED drivers. Each raw switch/button pin
//   passes through a synchroniser chain and a per-bit stability counter. The
//   block then publishes a clean level, one-cycle rise/fall pulses, and a
//   single-entry change-event slot behind a valid/ready handshake. Seven-seg
//   or counter logic downstream reads events from that slot.
//
// Parameters:
//   WIDTH        number of independent input bits
//   CLK_HZ       system clock frequency in Hz
//   DEBOUNCE_MS  time in ms that an input must hold a new level
//   SYNC_STAGES  synchroniser flops per bit (must be >= 2)
//
// Ports:
//   clk          system clock (HFOSC-derived)
//   reset        asynchronous, active-high reset
//   sw_raw       raw asynchronous pin inputs
//   sw_db        debounced level
//   rise         one-cycle pulse per bit on a debounced 0->1
//   fall         one-cycle pulse per bit on a debounced 1->0
//   evt_valid    a change event is pending
//   evt_data     sw_db snapshot for the pending event
//   evt_overrun  sticky: a pending event was overwritten before acceptance
//   evt_ready    consumer takes the event when evt_valid && evt_ready
//
// Configuration macro:
//   SW_INVERT_EN  when defined, the synchroniser samples ~sw_raw. Use this for
//                 active-low buttons, so an idle-high pin reads as 0. When it
//                 is undefined, sw_raw is used as-is.
//
// Reset assertion is asynchronous. The top-level reset generator must release
// reset in step with clk.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH       = 4,
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_overrun,
  input  logic             evt_ready
);

  // Number of consecutive mismatching cycles needed before sw_db follows the
  // synchronised input. Clamped to 1 so that tiny parameter sets still work.
  localparam int CNT_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT_MAX = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] pin_level;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] db_next;
  logic             change;

  // Active-low buttons are inverted before the synchroniser, so all logic past
  // this point treats 1 as "pressed/on".
`ifdef SW_INVERT_EN
  assign pin_level = ~sw_raw;
`else
  assign pin_level = sw_raw;
`endif

  // Synchroniser chain. Only the last stage (sync_s) is allowed to feed the
  // debounce logic. The earlier stages can go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pin_level;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Per-bit stability counter. While the synchronised input differs from the
  // published level, the counter climbs. If a cycle of agreement occurs, the
  // counter drops back to zero, so any bounce restarts the full wait. On the
  // CNT_MAX-th consecutive mismatch the level flips and the count clears, so
  // the counter never passes CNT_LAST.
  always_comb begin
    db_next = sw_db;
    for (int b = 0; b < WIDTH; b++) begin
      cnt_next[b] = '0;
      if (sync_s[b] != sw_db[b]) begin
        if (cnt[b] == CNT_LAST) begin
          db_next[b] = sync_s[b];
        end else begin
          cnt_next[b] = cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level and edge pulses share one register stage. The pulse is
  // therefore high during exactly the first cycle in which sw_db shows the
  // new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_db <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      sw_db <= db_next;
      rise  <= db_next & ~sw_db;
      fall  <= ~db_next & sw_db;
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= cnt_next[b];
      end
    end
  end

  assign change = |(rise | fall);

  // Single-entry event slot. A change always loads the newest snapshot.
  // - If the old event is still pending and the consumer is not taking it,
  //   the old event is lost and overrun is flagged.
  // - If the consumer takes the old event in that same cycle, nothing is
  //   lost, so overrun clears and the new event becomes pending.
  // - An accept with no change empties the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else if (change) begin
      evt_valid <= 1'b1;
      evt_data  <= sw_db;
      if (evt_valid && !evt_ready) begin
        evt_overrun <= 1'b1;
      end else if (evt_valid && evt_ready) begin
        evt_overrun <= 1'b0;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid   <= 1'b0;
      evt_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Drives logical switch levels. When SW_INVERT_EN is defined, each level is
// mapped onto the pins as its inverse. Every cycle the bench compares the DUT
// against a behavioural reference:
//   - the debounced level flips when the synchronised level has disagreed with
//     it for the last CNT_MAX edges since its previous flip;
//   - the event slot follows the pending/accept/overwrite rules.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int WIDTH       = 4;
  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (CLK_HZ / 1000) * DEBOUNCE_MS;

`ifdef SW_INVERT_EN
  localparam logic [WIDTH-1:0] PIN_XOR = 4'b1111;
`else
  localparam logic [WIDTH-1:0] PIN_XOR = 4'b0000;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db, rise, fall, evt_data;
  logic             evt_valid, evt_overrun;
  logic             evt_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  switch_debouncer #(
    .WIDTH(WIDTH), .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_db(sw_db), .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_overrun(evt_overrun), .evt_ready(evt_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_q[$];
  logic [WIDTH-1:0] seen_q[$];
  int               edge_n;
  int               last_flip[WIDTH];
  logic [WIDTH-1:0] m_db, m_rise, m_fall, m_data;
  logic             m_valid, m_overrun;

  task automatic set_level(input logic [WIDTH-1:0] v);
    level  = v;
    sw_raw = v ^ PIN_XOR;
  endtask

  task automatic model_reset();
    level_q.delete();
    seen_q.delete();
    edge_n = 0;
    for (int b = 0; b < WIDTH; b++) last_flip[b] = 0;
    m_db = '0; m_rise = '0; m_fall = '0; m_data = '0;
    m_valid = 1'b0; m_overrun = 1'b0;
  endtask

  // One clock edge in the reference model
  task automatic model_edge();
    logic [WIDTH-1:0] seen, flip;
    logic change, ok;
    edge_n++;
    level_q.push_front(level);
    if (level_q.size() > 64) void'(level_q.pop_back());
    seen = (level_q.size() > SYNC_STAGES) ? level_q[SYNC_STAGES] : '0;
    seen_q.push_front(seen);
    if (seen_q.size() > 64) void'(seen_q.pop_back());
    flip = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (edge_n - last_flip[b] >= CNT_MAX) begin
        ok = 1'b1;
        for (int j = 0; j < CNT_MAX; j++) if (seen_q[j][b] == m_db[b]) ok = 1'b0;
        if (ok) begin
          flip[b] = 1'b1;
          last_flip[b] = edge_n;
        end
      end
    end
    change = |(m_rise | m_fall);
    if (change) begin
      if (m_valid && !evt_ready) m_overrun = 1'b1;
      else if (m_valid) m_overrun = 1'b0;
      m_valid = 1'b1;
      m_data  = m_db;
    end else if (m_valid && evt_ready) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
    m_rise = flip & ~m_db;
    m_fall = flip & m_db;
    m_db   = m_db ^ flip;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic string dut_str();
    return $sformatf("db=%b rise=%b fall=%b v=%b data=%b ovr=%b",
                     sw_db, rise, fall, evt_valid, evt_data, evt_overrun);
  endfunction

  function automatic string model_str();
    return $sformatf("db=%b rise=%b fall=%b v=%b data=%b ovr=%b",
                     m_db, m_rise, m_fall, m_valid, m_data, m_overrun);
  endfunction

  // Reset held with 1010 on the inputs. Everything must stay zero.
  task automatic test_reset();
    reset = 1'b1;
    set_level(4'b1010);
    evt_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !== 18'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %s want all zero", dut_str());
    end
    reset = 1'b0;
  endtask

  // Release with 1010 stable: sw_db rises on cycle 6, and the event follows on cycle 7
  task automatic test_startup();
    for (int c = 1; c <= 7; c++) begin
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL startup_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
      vectors++;
      if (c <= 5 && sw_db !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL startup_early cyc %0d sw_db got %b want 0000", c, sw_db);
      end else if (c == 6 && (sw_db !== 4'b1010 || rise !== 4'b1010)) begin
        miscompares++;
        $display("[TB] FAIL startup_flip sw_db=%b rise=%b want 1010/1010", sw_db, rise);
      end else if (c == 7 && (rise !== 4'b0000 || evt_valid !== 1'b1 || evt_data !== 4'b1010)) begin
        miscompares++;
        $display("[TB] FAIL startup_event rise=%b v=%b data=%b want 0000/1/1010", rise, evt_valid, evt_data);
      end
    end
  endtask

  // Bit 0 bounces every 2 cycles. It must never get through the debouncer.
  task automatic test_bounce();
    evt_ready = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) set_level(level ^ 4'b0001);
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL bounce_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
      vectors++;
      if (sw_db !== 4'b1010 || (rise | fall) !== 4'b0000 || evt_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bounce_const cyc %0d got %s want db=1010 no pulses v=0", c, dut_str());
      end
    end
    repeat (6) tick();
  endtask

  // Two changes with no accept in between: overrun, then a single accept clears it
  task automatic test_overrun();
    evt_ready = 1'b0;
    set_level(4'b0001);
    repeat (8) tick();
    set_level(4'b0011);
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL overrun_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
    end
    vectors++;
    if (sw_db !== 4'b0011 || evt_valid !== 1'b1 || evt_data !== 4'b0011 || evt_overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_set got %s want db=0011 v=1 data=0011 ovr=1", dut_str());
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    vectors++;
    if (evt_valid !== 1'b0 || evt_overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overrun_accept got v=%b ovr=%b want 0/0", evt_valid, evt_overrun);
    end
  endtask

  // Accept lands in the same cycle as a new change, so the slot reloads with no overrun
  task automatic test_back_to_back();
    evt_ready = 1'b0;
    set_level(4'b0001);
    repeat (8) tick();
    set_level(4'b0111);
    for (int c = 1; c <= 6; c++) begin
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL b2b_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
    end
    vectors++;
    if (evt_valid !== 1'b1 || evt_data !== 4'b0001 || rise !== 4'b0110) begin
      miscompares++;
      $display("[TB] FAIL b2b_pending got %s want v=1 data=0001 rise=0110", dut_str());
    end
    evt_ready = 1'b1;
    tick();
    vectors++;
    if (evt_valid !== 1'b1 || evt_data !== 4'b0111 || evt_overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_collide got v=%b data=%b ovr=%b want 1/0111/0", evt_valid, evt_data, evt_overrun);
    end
    tick();
    evt_ready = 1'b0;
    vectors++;
    if (evt_valid !== m_valid || evt_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain got v=%b want 0", evt_valid);
    end
  endtask

  // Reset while the counter is at 3: outputs clear at once, and the full latency restarts
  task automatic test_reset_midcount();
    set_level(4'b0000);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !== 18'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got %s want all zero", dut_str());
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_level(4'b1000);
    for (int c = 1; c <= 7; c++) begin
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL restart_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
      vectors++;
      if ((c <= 5 && sw_db !== 4'b0000) || (c == 6 && sw_db !== 4'b1000)) begin
        miscompares++;
        $display("[TB] FAIL restart_latency cyc %0d sw_db got %b", c, sw_db);
      end
    end
  endtask

  // Idle pins, then bit 2 goes active. In the inverted build this means pin 2 drops low.
  task automatic test_idle_pins();
    int pulses;
    evt_ready = 1'b1;
    set_level(4'b0000);
    repeat (10) tick();
    vectors++;
    if (sw_db !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL idle_level pins=%b sw_db got %b want 0000", sw_raw, sw_db);
    end
    set_level(4'b0100);
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rise[2] === 1'b1) pulses++;
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL idle_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
      if (c == 6) begin
        vectors++;
        if (sw_db !== 4'b0100 || rise !== 4'b0100) begin
          miscompares++;
          $display("[TB] FAIL idle_flip pins=%b sw_db=%b rise=%b want 0100/0100", sw_raw, sw_db, rise);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL idle_pulse_count got %0d want 1", pulses);
    end
  endtask

  // Random holds of 1..7 cycles (mixing bounces and real changes) with random ready
  task automatic test_random();
    int hold;
    logic [WIDTH-1:0] lv;
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 2) == 0) lv = WIDTH'($urandom);
        else lv = level ^ (4'b0001 << $urandom_range(0, WIDTH-1));
        set_level(lv);
        hold = $urandom_range(1, 7);
      end
      hold--;
      evt_ready = ($urandom_range(0, 1) == 1);
      tick();
      vectors++;
      if ({sw_db, rise, fall, evt_valid, evt_data, evt_overrun} !==
          {m_db, m_rise, m_fall, m_valid, m_data, m_overrun}) begin
        miscompares++;
        $display("[TB] FAIL random_model cyc %0d got %s want %s", c, dut_str(), model_str());
      end
    end
  endtask

  initial begin
    set_level(4'b0000);
    test_reset();
    test_startup();
    test_bounce();
    test_overrun();
    test_back_to_back();
    test_reset_midcount();
    test_idle_pins();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
